fnd_scan_controller: RTL and testbench

- Upstream driver for the 4-digit FND path: accepts a 14-bit binary number and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits at a parameterised scan rate.
- Drives o_digitSelect/o_en into FND_Select_Decoder (i_digitSelect/i_en) and o_value into BCDtoFND_Decoder (i_value).

---
 rtl/fnd_scan_controller.sv | 166 ++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan driver: iterative binary-to-BCD conversion feeding a
// continuously time-multiplexed digit display with optional leading-zero blanking.
module fnd_scan_controller #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned BIN_W    = 14
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [BIN_W-1:0] i_bin,
    input  logic             i_blank_lz,
    output logic             o_busy,
    output logic             o_ovf,
    output logic [1:0]       o_digitSelect,
    output logic [3:0]       o_value,
    output logic             o_en
);

    localparam int unsigned BCD_W    = 16;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned CNT_W    = $clog2(BIN_W + 1);
    localparam int unsigned PRE_W    = $clog2(SCAN_DIV);
    localparam int unsigned MAX_DISP = 9999;
    localparam logic [BCD_W-1:0] ALL_NINES = BCD_W'(16'h9999);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0] disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;

    logic [PRE_W-1:0] pre_q;
    logic [1:0]       idx_q;

    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] tail_zero;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: next state and datapath next values.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (i_load) begin
                    bin_d      = i_bin;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(i_bin) > MAX_DISP);
                    state_d    = CONV;
                end
            end
            CONV: begin
                bcd_d = BCD_W'({bcd_adj, bin_q[BIN_W-1]});
                bin_d = BIN_W'({bin_q, 1'b0});
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Display registers only ever take a finished result.
                disp_d  = ovf_pend_q ? ALL_NINES : bcd_q;
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state and conversion datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    // Free-running scan prescaler and digit index, independent of the FSM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pre_q <= '0;
            idx_q <= 2'd0;
        end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit_zero[i] = (disp_q[4*i +: 4] == 4'd0);
        end
    end

    // tail_zero[i]: digits i..3 are all zero.
    always_comb begin
        tail_zero[3] = digit_zero[3];
        tail_zero[2] = digit_zero[2] & digit_zero[3];
        tail_zero[1] = digit_zero[1] & digit_zero[2] & digit_zero[3];
        tail_zero[0] = &digit_zero;
    end

    always_comb begin
        o_value = 4'd0;
        case (idx_q)
            2'd0:    o_value = disp_q[3:0];
            2'd1:    o_value = disp_q[7:4];
            2'd2:    o_value = disp_q[11:8];
            2'd3:    o_value = disp_q[15:12];
            default: o_value = 4'd0;
        endcase
    end

    assign o_en          = ~(i_blank_lz && (idx_q != 2'd0) && tail_zero[idx_q]);
    assign o_busy        = busy_q;
    assign o_ovf         = ovf_q;
    assign o_digitSelect = idx_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: per-cycle comparison against an arithmetic
// reference model plus fixed-value checks for each scenario.
module tb_fnd_scan_controller;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_load = 1'b0;
    logic [13:0] i_bin = '0;
    logic        i_blank_lz = 1'b0;
    logic        o_busy;
    logic        o_ovf;
    logic [1:0]  o_digitSelect;
    logic [3:0]  o_value;
    logic        o_en;

    fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .BIN_W(14)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_load        (i_load),
        .i_bin         (i_bin),
        .i_blank_lz    (i_blank_lz),
        .o_busy        (o_busy),
        .o_ovf         (o_ovf),
        .o_digitSelect (o_digitSelect),
        .o_value       (o_value),
        .o_en          (o_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: edges since reset, remaining busy cycles, shown integer.
    int m_n = 0;
    int m_left = 0;
    int m_disp = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;
    bit m_pend_ovf = 1'b0;
    int pw [4] = '{1, 10, 100, 1000};

    always @(posedge clk) begin
        if (i_reset) begin
            m_n = 0;
            m_left = 0;
            m_disp = 0;
            m_ovf = 1'b0;
        end else begin
            m_n++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_disp = m_pend;
                    m_ovf = m_pend_ovf;
                end
            end else if (i_load) begin
                m_left = 15;
                m_pend_ovf = (int'(i_bin) > 9999);
                m_pend = m_pend_ovf ? 9999 : int'(i_bin);
            end
        end
    end

    // Expected {busy, ovf, select, value, en} from the model.
    function automatic logic [8:0] exp_vec();
        int idx;
        int p;
        logic [3:0] v;
        logic en;
        idx = (m_n / int'(SCAN_DIV)) % 4;
        p = pw[idx];
        v = 4'((m_disp / p) % 10);
        en = !(i_blank_lz && idx != 0 && m_disp < p);
        return {(m_left > 0), m_ovf, 2'(idx), v, en};
    endfunction

    task automatic tick(input logic ld, input logic [13:0] b, input logic rst);
        i_load = ld;
        i_bin = b;
        i_reset = rst;
        @(posedge clk);
        @(negedge clk);
        i_load = 1'b0;
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b0, 14'd0, 1'b1);
        tick(1'b1, 14'd77, 1'b1);
        checks++;
        if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== 9'b0_0_00_0000_1) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {o_busy, o_ovf, o_digitSelect, o_value, o_en}, 9'b0_0_00_0000_1);
        end
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 14'd0, 1'b0);
            checks++;
            if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== exp_vec()) begin
                failures++;
                $display("FAIL reset_scan cyc=%0d got=%b exp=%b", i, {o_busy, o_ovf, o_digitSelect, o_value, o_en}, exp_vec());
            end
        end
    endtask

    task automatic test_convert();
        int busy_cnt;
        logic [3:0] seen [4];
        logic [15:0] seen_v;
        logic all_en;
        busy_cnt = 0;
        all_en = 1'b1;
        tick(1'b1, 14'd1234, 1'b0);
        busy_cnt += int'(o_busy);
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, 14'd0, 1'b0);
            busy_cnt += int'(o_busy);
            if (i >= 15) begin
                seen[o_digitSelect] = o_value;
                all_en = all_en & o_en;
            end
            checks++;
            if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== exp_vec()) begin
                failures++;
                $display("FAIL convert_1234 cyc=%0d got=%b exp=%b", i, {o_busy, o_ovf, o_digitSelect, o_value, o_en}, exp_vec());
            end
        end
        seen_v = {seen[3], seen[2], seen[1], seen[0]};
        checks++;
        if (busy_cnt !== 15) begin
            failures++;
            $display("FAIL busy_length got=%0d exp=15", busy_cnt);
        end
        checks++;
        if (seen_v !== 16'h1234 || all_en !== 1'b1) begin
            failures++;
            $display("FAIL digits_1234 got=%h en=%b exp=1234 en=1", seen_v, all_en);
        end
    endtask

    task automatic test_ovf();
        int vals [3] = '{9999, 16383, 0};
        logic [15:0] exp_d [3] = '{16'h9999, 16'h9999, 16'h0000};
        logic exp_o [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0] seen [4];
        logic [15:0] seen_v;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 14'(vals[k]), 1'b0);
            for (int i = 1; i < 32; i++) begin
                tick(1'b0, 14'd0, 1'b0);
                if (i >= 15) seen[o_digitSelect] = o_value;
                checks++;
                if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== exp_vec()) begin
                    failures++;
                    $display("FAIL ovf_scan val=%0d cyc=%0d got=%b exp=%b", vals[k], i, {o_busy, o_ovf, o_digitSelect, o_value, o_en}, exp_vec());
                end
            end
            seen_v = {seen[3], seen[2], seen[1], seen[0]};
            checks++;
            if (seen_v !== exp_d[k] || o_ovf !== exp_o[k]) begin
                failures++;
                $display("FAIL ovf_result val=%0d got=%h ovf=%b exp=%h ovf=%b", vals[k], seen_v, o_ovf, exp_d[k], exp_o[k]);
            end
        end
    endtask

    task automatic test_blank();
        int vals [4] = '{7, 40, 305, 0};
        logic [3:0] exp_en [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0001};
        logic [3:0] seen_en;
        i_blank_lz = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seen_en = 4'b0000;
            tick(1'b1, 14'(vals[k]), 1'b0);
            for (int i = 1; i < 32; i++) begin
                tick(1'b0, 14'd0, 1'b0);
                if (i >= 15) seen_en[o_digitSelect] = o_en;
                checks++;
                if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== exp_vec()) begin
                    failures++;
                    $display("FAIL blank_scan val=%0d cyc=%0d got=%b exp=%b", vals[k], i, {o_busy, o_ovf, o_digitSelect, o_value, o_en}, exp_vec());
                end
            end
            checks++;
            if (seen_en !== exp_en[k]) begin
                failures++;
                $display("FAIL blank_en val=%0d got=%b exp=%b", vals[k], seen_en, exp_en[k]);
            end
        end
        i_blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] first [4];
        logic [3:0] second [4];
        logic [15:0] first_v;
        logic [15:0] second_v;
        tick(1'b1, 14'd5678, 1'b0);
        for (int i = 1; i < 47; i++) begin
            tick((i == 5) || (i == 16), 14'd1111, 1'b0);
            if (i >= 15 && i < 31) first[o_digitSelect] = o_value;
            if (i >= 31) second[o_digitSelect] = o_value;
            checks++;
            if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_scan cyc=%0d got=%b exp=%b", i, {o_busy, o_ovf, o_digitSelect, o_value, o_en}, exp_vec());
            end
        end
        first_v = {first[3], first[2], first[1], first[0]};
        second_v = {second[3], second[2], second[1], second[0]};
        checks++;
        if (first_v !== 16'h5678 || second_v !== 16'h1111) begin
            failures++;
            $display("FAIL b2b_digits got=%h,%h exp=5678,1111", first_v, second_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seen [4];
        logic [15:0] seen_v;
        tick(1'b1, 14'd4321, 1'b0);
        for (int i = 1; i < 8; i++) tick(1'b0, 14'd0, 1'b0);
        tick(1'b0, 14'd0, 1'b1);
        checks++;
        if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== 9'b0_0_00_0000_1) begin
            failures++;
            $display("FAIL reset_mid_state got=%b exp=%b", {o_busy, o_ovf, o_digitSelect, o_value, o_en}, 9'b0_0_00_0000_1);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 14'd0, 1'b0);
            checks++;
            if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid_scan cyc=%0d got=%b exp=%b", i, {o_busy, o_ovf, o_digitSelect, o_value, o_en}, exp_vec());
            end
        end
        tick(1'b1, 14'd4321, 1'b0);
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, 14'd0, 1'b0);
            if (i >= 15) seen[o_digitSelect] = o_value;
        end
        seen_v = {seen[3], seen[2], seen[1], seen[0]};
        checks++;
        if (seen_v !== 16'h4321) begin
            failures++;
            $display("FAIL reset_mid_reload got=%h exp=4321", seen_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                i_blank_lz = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== exp_vec()) begin
                    failures++;
                    $display("FAIL rand_blank cyc=%0d got=%b exp=%b", i, {o_busy, o_ovf, o_digitSelect, o_value, o_en}, exp_vec());
                end
            end
            tick($urandom_range(0, 5) == 0, 14'($urandom_range(0, 16383)), $urandom_range(0, 299) == 0);
            checks++;
            if ({o_busy, o_ovf, o_digitSelect, o_value, o_en} !== exp_vec()) begin
                failures++;
                $display("FAIL rand_scan cyc=%0d got=%b exp=%b", i, {o_busy, o_ovf, o_digitSelect, o_value, o_en}, exp_vec());
            end
        end
        i_blank_lz = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_convert();
        test_ovf();
        test_blank();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
